// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the multi-channel programmable clock divider.
package clkdiv_pkg;

  // Select width is never allowed to collapse to zero bits, even with a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CHANNELS_DEFAULT = 4;
  localparam int CNT_W_DEFAULT    = 19;
  localparam int DIV_DEFAULT      = 500000;
  localparam int SEL_W            = sel_width(CHANNELS_DEFAULT);

endpackage

// File: rtl/div_channel.sv
// One divider channel: up-counter against an active divisor, with a shadow divisor
// that is only promoted on a wrap (or at once while the channel is idle or stalled).
module div_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic             tick,
  output logic             sq,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] active_div_reg, active_div_next;
  logic [CNT_W-1:0] shadow_div_reg, shadow_div_next;
  logic [CNT_W-1:0] last_cnt;
  logic             tick_reg, tick_next;
  logic             sq_reg, sq_next;
  logic             busy_reg, busy_next;
  logic             stalled, wrap, xfer;

  // Terminal count is only formed for a non-zero divisor, so it can never underflow.
  always_comb begin
    last_cnt = '0;
    if (active_div_reg != '0) last_cnt = active_div_reg - CNT_W'(1);
  end

  assign stalled = (active_div_reg == '0);
  assign wrap    = en && !stalled && (cnt_reg >= last_cnt);
  assign xfer    = busy_reg && (!en || stalled || wrap);

  always_comb begin
    cnt_next  = cnt_reg;
    tick_next = 1'b0;
    sq_next   = sq_reg;
    if (!en) begin
      cnt_next = '0;
    end else if (wrap) begin
      cnt_next  = '0;
      tick_next = 1'b1;
      sq_next   = ~sq_reg;
    end else if (!stalled) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // A write landing on the transfer cycle re-arms busy with the newer shadow value.
  always_comb begin
    active_div_next = xfer ? shadow_div_reg : active_div_reg;
    shadow_div_next = we ? wdata : shadow_div_reg;
    busy_next       = we | (busy_reg & ~xfer);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg        <= '0;
      tick_reg       <= 1'b0;
      sq_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      active_div_reg <= RST_DIV;
      shadow_div_reg <= RST_DIV;
    end else begin
      cnt_reg        <= cnt_next;
      tick_reg       <= tick_next;
      sq_reg         <= sq_next;
      busy_reg       <= busy_next;
      active_div_reg <= active_div_next;
      shadow_div_reg <= shadow_div_next;
    end
  end

  assign tick = tick_reg;
  assign sq   = sq_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/clock_div_multi.sv
// N-channel programmable clock divider; the top only decodes divisor writes
// into per-channel strobes and replicates div_channel.
module clock_div_multi
  import clkdiv_pkg::*;
#(
  parameter int  CHANNELS    = CHANNELS_DEFAULT,
  parameter int  CNT_W       = CNT_W_DEFAULT,
  parameter int  DEFAULT_DIV = DIV_DEFAULT,
  localparam int CH_SEL_W    = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                div_we,
  input  logic [CH_SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0]    div_data,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq_out,
  output logic [CHANNELS-1:0] busy
);

  logic [CHANNELS-1:0] we_ch;

  // Select values with no matching channel simply produce no strobe.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign we_ch[gi] = div_we && (div_sel == CH_SEL_W'(gi));

    div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .en    (ch_en[gi]),
      .we    (we_ch[gi]),
      .wdata (div_data),
      .tick  (tick[gi]),
      .sq    (sq_out[gi]),
      .busy  (busy[gi])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi: per-cycle comparison against a behavioural
// channel model, plus hand-computed checkpoints for each scenario.
module tb_clock_div_multi;

  localparam int CH = 4;
  localparam int CW = 19;
  localparam int DD = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          div_we;
  logic [1:0]    div_sel;
  logic [CW-1:0] div_data;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] tick, sq_out, busy;

  int tests = 0;
  int fails = 0;

  clock_div_multi #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(DD)) dut (
    .clk      (clk),
    .reset    (reset),
    .div_we   (div_we),
    .div_sel  (div_sel),
    .div_data (div_data),
    .ch_en    (ch_en),
    .tick     (tick),
    .sq_out   (sq_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Model: phase = clocks counted since the last restart; a tick is due when
  // the clock about to be counted completes a full period of act clocks.
  typedef struct {
    int phase;
    int act;
    int shd;
    bit pend;
    bit tk;
    bit sq;
  } mch_t;

  mch_t m [CH];
  bit   armed = 1'b0;
  logic [CH-1:0] exp_tick, exp_sq, exp_busy;

  function automatic mch_t m_step(mch_t s, bit rst_n, bit en, bit wr, int data);
    mch_t n = s;
    bit   apply = 1'b0;
    if (!rst_n) begin
      n.phase = 0; n.act = DD; n.shd = DD; n.pend = 0; n.tk = 0; n.sq = 0;
      return n;
    end
    n.tk = 0;
    if (!en) begin
      n.phase = 0;
      apply   = s.pend;
    end else if (s.act == 0) begin
      apply = s.pend;
    end else if (s.phase + 1 == s.act) begin
      n.phase = 0;
      n.tk    = 1;
      n.sq    = !s.sq;
      apply   = s.pend;
    end else begin
      n.phase = s.phase + 1;
    end
    if (apply) begin
      n.act  = s.shd;
      n.pend = 0;
    end
    if (wr) begin
      n.shd  = data;
      n.pend = 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < CH; i++)
      m[i] <= m_step(m[i], reset, ch_en[i], div_we && (int'(div_sel) == i), int'(div_data));
    if (!reset) armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < CH; i++) begin
        exp_tick[i] = m[i].tk;
        exp_sq[i]   = m[i].sq;
        exp_busy[i] = m[i].pend;
      end
      tests++;
      if (tick !== exp_tick || sq_out !== exp_sq || busy !== exp_busy) begin
        fails++;
        $display("FAIL model_cycle t=%0t tick=%b sq=%b busy=%b required tick=%b sq=%b busy=%b",
                 $time, tick, sq_out, busy, exp_tick, exp_sq, exp_busy);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h required=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit e_t, e_s;

  initial begin
    reset = 1'b0; div_we = 1'b0; div_sel = '0; div_data = '0; ch_en = '0;
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_sq", sq_out, 0);
    chk("rst_busy", busy, 0);

    // 1: default divisor on ch0
    reset = 1'b1; ch_en = 4'b0001;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("t1_tick", tick, (k == DD) ? 4'b0001 : 4'b0000);
      chk("t1_sq", sq_out, (k >= DD) ? 4'b0001 : 4'b0000);
    end

    // 2: ch1 div 4, then a mid-count write of 6
    div_we = 1'b1; div_sel = 2'd1; div_data = 4;
    step();
    div_we = 1'b0;
    chk("t2_busy_set", busy[1], 1);
    step();
    chk("t2_busy_idle_xfer", busy[1], 0);
    ch_en = 4'b0011;
    for (int k = 1; k <= 22; k++) begin
      div_we = (k == 14); div_data = 6;
      step();
      e_t = (k == 4 || k == 8 || k == 12 || k == 16 || k == 22);
      chk("t2_tick", tick[1], e_t);
      chk("t2_busy", busy[1], (k == 14 || k == 15));
    end
    div_we = 1'b0;
    chk("t2_sq", sq_out[1], 1);
    ch_en = 4'b0001;

    // 3: ch2 div 1, then div 0 stalls it
    div_we = 1'b1; div_sel = 2'd2; div_data = 1;
    step();
    div_we = 1'b0;
    step();
    ch_en = 4'b0101;
    for (int k = 1; k <= 8; k++) begin
      div_we = (k == 4); div_sel = 2'd2; div_data = 0;
      step();
      chk("t3_tick", tick[2], (k <= 5));
      chk("t3_sq", sq_out[2], (k <= 5) ? (k % 2) : 1);
      chk("t3_busy", busy[2], (k == 4));
    end
    div_we = 1'b0;

    // 4+5: ch1 div 4, disable at cnt=2, re-enable, then write 3 on a wrap cycle
    div_we = 1'b1; div_sel = 2'd1; div_data = 4;
    step();
    div_we = 1'b0;
    step();
    e_s = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      ch_en  = {1'b0, 1'b1, !(k >= 3 && k <= 5), 1'b1};
      div_we = (k == 13); div_sel = 2'd1; div_data = 3;
      step();
      e_t = (k == 9 || k == 13 || k == 17 || k == 20 || k == 23);
      if (e_t) e_s = !e_s;
      chk("t45_tick", tick[1], e_t);
      chk("t45_sq", sq_out[1], e_s);
      chk("t45_busy", busy[1], (k >= 13 && k <= 16));
    end
    div_we = 1'b0;

    // 6: reset with writes pending
    div_we = 1'b1; div_sel = 2'd0; div_data = 5;
    step();
    div_sel = 2'd1; div_data = 7;
    step();
    div_we = 1'b0;
    chk("t6_pending", busy & 4'b0011, 4'b0011);
    reset = 1'b0;
    step();
    chk("t6_tick", tick, 0);
    chk("t6_sq", sq_out, 0);
    chk("t6_busy", busy, 0);
    reset = 1'b1; ch_en = 4'b1111;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("t6_default_tick", tick, (k == DD) ? 4'b1111 : 4'b0000);
    end
    chk("t6_default_sq", sq_out, 4'b1111);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
